// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg
//   Shared definitions for the product accumulator slice: the FSM state
//   encoding and the default sizing constants used by prod_accumulator and
//   acc_add.
//   Configuration macro: PROD_ACC_SAT_EN (saturating accumulation, see acc_add).
package prod_acc_pkg;

    // Default accumulator/result width and maximum products per packet.
    localparam int ACC_W_DEF     = 12;
    localparam int MAX_TERMS_DEF = 32;
    localparam int PROD_W        = 8;

    // Packet FSM states.
    //   IDLE  : waiting for the first beat of a packet
    //   ACCUM : packet open, summing further beats
    //   HOLD  : result presented, waiting for the consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

endpackage : prod_acc_pkg

// File: rtl/acc_add.sv
// acc_add
//   ACC_W-bit adder of the running accumulator and one 8-bit unsigned product,
//   with carry out of bit ACC_W-1.
//   Configuration macro: PROD_ACC_SAT_EN
//     defined   : sum clamps to all-ones when this add carries or the packet has
//                 already overflowed, so a clamped packet stays clamped.
//     undefined : sum wraps modulo 2^ACC_W.
//   The carry output is identical in both modes.
// Ports
//   acc    [ACC_W-1:0] in  : current accumulator value
//   prod   [7:0]       in  : product to add (zero-extended)
//   ovf_in             in  : packet has already overflowed
//   sum    [ACC_W-1:0] out : next accumulator value
//   carry              out : carry out of the ACC_W-bit add
module acc_add
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    input  logic              ovf_in,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry    = full_sum[ACC_W];
`ifdef PROD_ACC_SAT_EN
        sum      = (carry || ovf_in) ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
        sum      = full_sum[ACC_W-1:0];
`endif
    end

`ifndef PROD_ACC_SAT_EN
    // The sticky overflow only matters when clamping.
    logic unused_ovf_in;
    assign unused_ovf_in = ovf_in;
`endif

endmodule : acc_add

// File: rtl/prod_accumulator.sv
// prod_accumulator
//   Sums a packet of 8-bit unsigned products into an ACC_W-bit result and
//   presents the sum, the term count and a sticky overflow flag.
//   A packet closes on the beat carrying in_last or on the MAX_TERMS-th beat,
//   whichever comes first; the result appears the following cycle.
//   Configuration macro: PROD_ACC_SAT_EN (saturate instead of wrap, in acc_add).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The sender holds valid and its payload until that edge; the
//   receiver may raise or lower ready freely. Here in_ready is high in IDLE and
//   ACCUM only, and out_valid is high in HOLD only, so no input beat is taken in
//   the cycle where the result is handed off.
//
// Ports
//   clk                 in  : clock, rising edge
//   rst_n               in  : asynchronous active-low reset
//   in_valid/in_ready       : product input handshake
//   in_prod   [7:0]     in  : product (0..225)
//   in_last             in  : final term of the packet
//   out_valid/out_ready     : result output handshake
//   out_sum   [ACC_W-1:0] out : accumulated sum (0 when out_valid=0)
//   out_terms [CNT_W-1:0] out : products in the packet (0 when out_valid=0)
//   out_ovf             out : sum exceeded 2^ACC_W-1 (0 when out_valid=0)
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_terms,
    output logic              out_ovf
);

    // FSM state; kept as a named register so checkers can bind to it.
    acc_state_t state_q;
    acc_state_t state_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic             accept;
    logic [CNT_W-1:0] count_after;
    logic             close_beat;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .acc    (acc_q),
        .prod   (in_prod),
        .ovf_in (ovf_q),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    assign accept = in_valid && in_ready;

    // Term count including the beat being offered: a first beat restarts at 1.
    assign count_after = (state_q == IDLE) ? CNT_W'(1) : (count_q + CNT_W'(1));
    assign close_beat  = in_last || (count_after == CNT_W'(MAX_TERMS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = close_beat ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; result fields are forced to zero outside HOLD.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_sum   = '0;
        out_terms = '0;
        out_ovf   = 1'b0;
        if (state_q == HOLD) begin
            out_sum   = acc_q;
            out_terms = count_q;
            out_ovf   = ovf_q;
        end
    end

    // Datapath registers. They are only written on accepted beats, so the
    // result is frozen for as long as HOLD lasts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                acc_q   <= {{(ACC_W - PROD_W){1'b0}}, in_prod};
                count_q <= CNT_W'(1);
                ovf_q   <= 1'b0;
            end else begin
                acc_q   <= add_sum;
                count_q <= count_after;
                ovf_q   <= ovf_q | add_carry;
            end
        end
    end

endmodule : prod_accumulator

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator
//   Self-checking bench for prod_accumulator: a behavioural packet model
//   pushes expected {sum, terms, ovf} into a queue as beats are accepted, and
//   a monitor pops and compares on every output handshake.
//   Honours PROD_ACC_SAT_EN in its expected values.
module tb_prod_accumulator;

    localparam int ACC_W     = 12;
    localparam int MAX_TERMS = 32;
    localparam int CNT_W     = 6;
    localparam int RES_W     = ACC_W + CNT_W + 1;
    localparam int ACC_MAX   = (1 << ACC_W) - 1;
    localparam int WAIT_MAX  = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_prod = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_terms;
    logic             out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: {sum, terms, ovf} per expected result.
    logic [RES_W-1:0] exp_q[$];

    // Packet model state.
    int m_acc  = 0;
    int m_cnt  = 0;
    bit m_ovf  = 1'b0;
    bit m_open = 1'b0;

    prod_accumulator #(
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_terms (out_terms),
        .out_ovf   (out_ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model of one accepted beat; returns 1 when the beat closes the packet.
    function automatic bit model_beat(input int p, input bit l);
        int s;
        bit carry;
        if (!m_open) begin
            m_acc  = p;
            m_cnt  = 1;
            m_ovf  = 1'b0;
            m_open = 1'b1;
        end else begin
            s     = m_acc + p;
            carry = (s > ACC_MAX);
            m_ovf = m_ovf | carry;
            m_cnt = m_cnt + 1;
`ifdef PROD_ACC_SAT_EN
            m_acc = m_ovf ? ACC_MAX : s;
`else
            m_acc = s & ACC_MAX;
`endif
        end
        if (l || m_cnt == MAX_TERMS) begin
            exp_q.push_back({ACC_W'(m_acc), CNT_W'(m_cnt), m_ovf});
            m_open = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; offers one beat and returns at posedge+1 after it is
    // accepted. in_valid is left high so beats can follow back to back.
    task automatic send_beat(input logic [7:0] p, input bit l, output int waits);
        bit acc_seen;
        bit closed;
        waits     = 0;
        acc_seen  = 1'b0;
        in_valid  = 1'b1;
        in_prod   = p;
        in_last   = l;
        while (!acc_seen && waits < WAIT_MAX) begin
            @(negedge clk);
            acc_seen = in_ready;
            @(posedge clk);
            #1;
            if (!acc_seen) waits++;
        end
        if (!acc_seen) begin
            check_eq("accept_timeout", 32'(waits), 32'(0));
        end else begin
            closed = model_beat(int'(p), l);
            if (closed) check_eq("latency_out_valid", 32'(out_valid), 32'(1));
        end
    endtask

    // Drop in_valid and put garbage on the payload, which must be ignored.
    task automatic idle_inputs();
        in_valid = 1'b0;
        in_prod  = 8'($urandom_range(0, 255));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check_eq({tag, "_out_fields"}, 32'({out_sum, out_terms, out_ovf}), 32'(0));
    endtask

    // ---------------- monitor ----------------
    logic [RES_W-1:0] exp_res;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                check_eq("hold_in_ready", 32'(in_ready), 32'(0));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_result", 32'(1), 32'(0));
                    end else begin
                        exp_res = exp_q.pop_front();
                        check_eq("out_sum", 32'(out_sum), 32'(exp_res[RES_W-1 -: ACC_W]));
                        check_eq("out_terms", 32'(out_terms), 32'(exp_res[CNT_W:1]));
                        check_eq("out_ovf", 32'(out_ovf), 32'(exp_res[0]));
                    end
                end
            end else begin
                check_eq("idle_zero", 32'({out_sum, out_terms, out_ovf}), 32'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    int w;
    int len;

    initial begin
        // Reset state.
        out_ready = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // Three-term packet, consumer ready.
        send_beat(8'd10, 1'b0, w);
        send_beat(8'd20, 1'b0, w);
        send_beat(8'd30, 1'b1, w);
        idle_inputs();
        wait_cycles(3);

        // Same packet with the consumer stalled for 5 cycles.
        out_ready = 1'b0;
        send_beat(8'd10, 1'b0, w);
        send_beat(8'd20, 1'b0, w);
        send_beat(8'd30, 1'b1, w);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_out_valid", 32'(out_valid), 32'(1));
            check_eq("stall_out_sum", 32'(out_sum), 32'(60));
            check_eq("stall_out_terms", 32'(out_terms), 32'(3));
            check_eq("stall_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_cycles(1);
        check_eq("release_in_ready", 32'(in_ready), 32'(1));
        check_eq("release_out_valid", 32'(out_valid), 32'(0));
        wait_cycles(2);

        // MAX_TERMS beats of 225 with no in_last: closes on its own.
        for (int i = 0; i < MAX_TERMS; i++) send_beat(8'd225, 1'b0, w);
        idle_inputs();
        wait_cycles(3);

        // Single zero beat.
        send_beat(8'd0, 1'b1, w);
        idle_inputs();
        wait_cycles(3);

        // Reset in the middle of a packet.
        send_beat(8'd7, 1'b0, w);
        send_beat(8'd9, 1'b0, w);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        m_open = 1'b0;
        wait_cycles(2);
        check_reset_outputs("mid_reset_held");
        rst_n = 1'b1;
        wait_cycles(1);
        send_beat(8'd5, 1'b1, w);
        idle_inputs();
        wait_cycles(3);

        // Back-to-back packets with in_valid held high.
        send_beat(8'd1, 1'b0, w);
        send_beat(8'd2, 1'b0, w);
        send_beat(8'd3, 1'b1, w);
        send_beat(8'd4, 1'b0, w);
        check_eq("b2b_gap", 32'(w), 32'(1));
        send_beat(8'd5, 1'b1, w);
        send_beat(8'd6, 1'b1, w);
        check_eq("b2b_gap_single", 32'(w), 32'(1));
        idle_inputs();
        wait_cycles(3);

        // Random packets, occasional idle gaps.
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                send_beat(8'($urandom_range(0, 225)), (i == len - 1), w);
                if ($urandom_range(0, 3) == 0) begin
                    idle_inputs();
                    wait_cycles($urandom_range(1, 2));
                end
            end
            idle_inputs();
            if ($urandom_range(0, 1) == 1) wait_cycles(2);
        end
        idle_inputs();
        wait_cycles(5);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_prod_accumulator

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator and result width in bits.
REQ-002 SHALL have parameter MAX_TERMS, default 32: maximum products per packet.
REQ-003 SHALL have parameter CNT_W, default 6: term-count width, which must be at least clog2(MAX_TERMS+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: a product is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a product.
REQ-008 SHALL have port in_prod, input, 8 bits: unsigned product from the 4x4 multiplier stage (0..225).
REQ-009 SHALL have port in_last, input, 1 bit: the offered product is the final term of the packet.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_sum, output, ACC_W bits: the accumulated sum.
REQ-013 SHALL have port out_terms, output, CNT_W bits: number of products in the packet.
REQ-014 SHALL have port out_ovf, output, 1 bit: the sum exceeded 2^ACC_W-1 at some point in the packet.

Function
REQ-015 SHALL implement states IDLE, ACCUM and HOLD.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-017 SHALL, on an accepted beat (in_valid&&in_ready) in IDLE: acc=in_prod zero-extended, count=1, ovf=0, next state ACCUM.
REQ-018 SHALL, on an accepted beat in ACCUM: acc=acc+in_prod, count+1, ovf|=carry out of ACC_W.
REQ-019 SHALL move to HOLD on the cycle after the accepted beat that has in_last=1 or brings count to MAX_TERMS, whichever comes first.
REQ-020 SHALL assert out_valid only in HOLD, one cycle after the closing beat is accepted (latency 1).
REQ-021 SHALL hold out_sum, out_terms and out_ovf stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid&&out_ready, return to IDLE with in_ready=1 in the next cycle; no new beat is accepted in the handshake cycle.
REQ-023 SHALL ignore in_prod and in_last when in_valid=0.
REQ-024 SHALL treat a single beat with in_last=1 in IDLE as a one-term packet (HOLD next cycle, out_terms=1).
REQ-025 SHALL drive out_sum, out_terms and out_ovf to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, put the FSM in IDLE and clear acc, count and ovf; outputs are in_ready=1 and out_valid, out_sum, out_terms, out_ovf = 0.
REQ-027 SHALL discard any partial packet or pending result when reset is asserted mid-operation; the first beat after reset release starts a new packet.

Configuration
REQ-028 SHALL, when PROD_ACC_SAT_EN is defined, clamp acc at 2^ACC_W-1 once a carry occurs and keep it clamped for the rest of the packet.
REQ-029 SHALL, when PROD_ACC_SAT_EN is undefined, wrap acc modulo 2^ACC_W; out_ovf is reported identically in both modes.

Structure
REQ-030 SHALL take the state enum (IDLE/ACCUM/HOLD) and the default ACC_W/MAX_TERMS constants from the shared package prod_acc_pkg.
REQ-031 SHALL place the ACC_W-bit add with carry out (and saturation under PROD_ACC_SAT_EN) in one sub-module, acc_add; the FSM and registers stay in prod_accumulator.

Verification
REQ-032 SHALL cover: products 10, 20, 30 (last on 30), out_ready=1 -> out_valid the cycle after the third accept; out_sum=60, out_terms=3, out_ovf=0.
REQ-033 SHALL cover: packet as in REQ-032 with out_ready=0 for 5 cycles -> out_valid, out_sum=60 and in_ready=0 held all 5 cycles; released on the handshake.
REQ-034 SHALL cover: 32 beats of 225 with no in_last -> auto-close after beat 32; out_terms=32, out_ovf=1, out_sum=3104 (wrap) or 4095 (PROD_ACC_SAT_EN).
REQ-035 SHALL cover: single beat in_prod=0 with in_last=1 -> out_sum=0, out_terms=1, out_ovf=0.
REQ-036 SHALL cover: rst_n pulsed low after 2 beats (7, 9) -> all outputs 0 and in_ready=1 during reset; next packet of one beat 5 (last) -> out_sum=5, out_terms=1.
REQ-037 SHALL cover: in_valid held high with packets back to back -> no beat accepted in HOLD; the next packet's first beat is accepted in the cycle after the output handshake, and no beats are lost.
